// File: rtl/sort_pkg.sv
// Shared types and the compare-swap schedule for the sequential 4-element sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  localparam int unsigned N_STEPS = 5;
  localparam int unsigned N_ELEM  = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned CNT_W   = 2;

  // Slot pair per step; the larger value ends up in the SEL_HI slot.
  localparam logic [SLOT_W-1:0] SEL_HI [N_STEPS] = '{2'd3, 2'd1, 2'd3, 2'd2, 2'd2};
  localparam logic [SLOT_W-1:0] SEL_LO [N_STEPS] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1};

endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-swap: hi = max(a,b), lo = min(a,b); ties keep a on hi.
//   a, b  : operands
//   hi, lo: ordered results
module cmp_swap #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  // Strictly-greater swap keeps equal values in place.
  always_comb begin
    hi = a;
    lo = b;
    if (b > a) begin
      hi = b;
      lo = a;
    end
  end

endmodule

// File: rtl/seq_sort4_nibble.sv
// Sequential descending sorter for four W-bit elements using one shared
// compare-swap unit stepped through a 5-comparator network.
//   clk, nrst            : clock, async active-low reset
//   in_valid/in_ready    : element input stream, in_data one element per beat
//   out_valid/out_ready  : result stream, out_data = {r3,r2,r1,r0}, largest on top
//   busy                 : high while sorting
module seq_sort4_nibble
  import sort_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*W-1:0]   out_data,
  output logic             busy
);

  localparam int unsigned OUT_W = 4 * W;

  sort_state_t        state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [STEP_W-1:0]  step, step_d, step_idx;
  logic [W-1:0]       elem   [N_ELEM];
  logic [W-1:0]       elem_d [N_ELEM];
  logic [SLOT_W-1:0]  hi_slot, lo_slot;
  logic [W-1:0]       cs_hi, cs_lo;
  logic               accept;

  logic               in_ready_d, out_valid_d, busy_d;
  logic [OUT_W-1:0]   out_data_d;

  assign accept = (state == LOAD) && in_valid;

  // Clamp the schedule index so non-SORT step values never address past the table.
  assign step_idx = (step < STEP_W'(N_STEPS)) ? step : '0;
  assign hi_slot  = SEL_HI[step_idx];
  assign lo_slot  = SEL_LO[step_idx];

  cmp_swap #(.W(W)) u_cmp_swap (
    .a  (elem[hi_slot]),
    .b  (elem[lo_slot]),
    .hi (cs_hi),
    .lo (cs_lo)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= LOAD;
    else       state <= state_d;
  end

  // Next-state logic; unknown encodings fall back to LOAD.
  always_comb begin
    state_d = state;
    case (state)
      LOAD: if (accept && (cnt == CNT_W'(N_ELEM - 1))) state_d = SORT;
      SORT: if (step == STEP_W'(N_STEPS - 1))          state_d = DONE;
      DONE: if (out_ready)                             state_d = LOAD;
      default:                                         state_d = LOAD;
    endcase
  end

  // Beat counter, step counter and element file updates.
  always_comb begin
    cnt_d  = cnt;
    step_d = '0;
    for (int i = 0; i < int'(N_ELEM); i++) elem_d[i] = elem[i];
    case (state)
      LOAD: begin
        if (accept) begin
          // Beat k lands in slot 3-k so arrival order matches the packed input word.
          elem_d[SLOT_W'(N_ELEM - 1) - cnt] = in_data;
          cnt_d = cnt + CNT_W'(1);
        end
      end
      SORT: begin
        elem_d[hi_slot] = cs_hi;
        elem_d[lo_slot] = cs_lo;
        step_d          = step + STEP_W'(1);
      end
      DONE: begin
        if (out_ready) cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the ports are flops.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SORT);
    out_data_d  = '0;
    if (state_d == DONE) out_data_d = {elem_d[3], elem_d[2], elem_d[1], elem_d[0]};
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      step      <= '0;
      for (int i = 0; i < int'(N_ELEM); i++) elem[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      cnt       <= cnt_d;
      step      <= step_d;
      for (int i = 0; i < int'(N_ELEM); i++) elem[i] <= elem_d[i];
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      out_data  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_seq_sort4_nibble.sv
// Directed bench for seq_sort4_nibble with hand-computed expected words.
module tb_seq_sort4_nibble;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_sort4_nibble #(.W(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; in_valid is left high.
  task automatic send_beat(input logic [3:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 30 && !done; t++) begin
      if (in_ready) done = 1;
      tick();
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Count edges until out_valid; returns 99 if it never rises.
  task automatic wait_result(output int lat);
    lat = 99;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (out_valid) begin
        lat = t;
        break;
      end
    end
  endtask

  // Four gapless beats, then latency, result and one-cycle handoff with out_ready=1.
  task automatic run_vector(input string tag, input logic [15:0] beats, input logic [15:0] exp);
    int lat;
    for (int i = 0; i < 4; i++) send_beat(beats[15 - 4*i -: 4]);
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_inrdy_sort"}, 32'(in_ready), 32'd0);
    wait_result(lat);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    tick();
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  logic [3:0]  gap_dat [7];
  logic        gap_vld [7];
  logic [3:0]  b2b     [8];
  logic [15:0] dres    [2];
  int          tres    [2];

  initial begin
    int lat;
    int cyc, bi, nres;
    bit acc;

    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    nrst = 1'b1;
    tick();

    run_vector("basic",   16'h3A1F, 16'hFA31);
    run_vector("sorted",  16'h0123, 16'h3210);
    run_vector("reverse", 16'hFEDC, 16'hFEDC);
    run_vector("tie7",    16'h7727, 16'h7772);
    run_vector("tie5",    16'h5555, 16'h5555);

    // Gapped input stream with backpressure on the result.
    gap_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_dat = '{4'h9, 4'hE, 4'hB, 4'h4, 4'h8, 4'h0, 4'hC};
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_vld[i];
      in_data  = gap_dat[i];
      tick();
    end
    in_valid = 1'b0;
    check("gap_busy", 32'(busy), 32'd1);
    wait_result(lat);
    check("gap_lat", 32'(lat), 32'd5);
    check("gap_data", 32'(out_data), 32'h0000C940);
    // Junk offered while not ready must be dropped.
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h0000C940);
      check("bp_inrdy", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'(out_valid), 32'd0);
    check("bp_inrdy_back", 32'(in_ready), 32'd1);

    // Reset in the middle of sorting (step 2 pending).
    for (int i = 0; i < 4; i++) send_beat(4'(8 - i));
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    run_vector("post_rst", 16'h1234, 16'h4321);

    // Back-to-back with in_valid and out_ready held high.
    b2b = '{4'h2, 4'h9, 4'h4, 4'h6, 4'hB, 4'h0, 4'hD, 4'h3};
    cyc  = 0;
    bi   = 0;
    nres = 0;
    in_valid = 1'b1;
    in_data  = b2b[0];
    while (nres < 2 && cyc < 60) begin
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) bi++;
      if (out_valid) begin
        dres[nres] = out_data;
        tres[nres] = cyc;
        nres++;
      end
      in_valid = (bi < 8);
      in_data  = (bi < 8) ? b2b[bi] : 4'h0;
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(nres), 32'd2);
    check("b2b_beats", 32'(bi), 32'd8);
    if (nres == 2) begin
      check("b2b_res1", 32'(dres[0]), 32'h00009642);
      check("b2b_res2", 32'(dres[1]), 32'h0000DB30);
      check("b2b_gap", 32'(tres[1] - tres[0]), 32'd10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
